// File: rtl/proj_nuc_streamer.sv
// Nucleotide streamer: unpacks packed words into one nucleotide per cycle
// for a k-mer shift buffer, with clear, k-mer-valid and done signalling.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   in_word/in_valid/in_ready      packed nucleotide word handshake
//   in_last/in_count               last-word flag and its nucleotide count
//   out_data/out_valid             nucleotide and shift enable
//   out_start_over                 one-cycle clear of the k-mer buffer
//   out_kmer_valid                 buffer holds a full k-mer
//   out_seq_done                   pulse after the last nucleotide

package proj_pkg;
  localparam int KMER_BUFFER_BITS = 2;
  localparam int KMER_BUFFER_LEN  = 32;
endpackage

module proj_nuc_streamer
  import proj_pkg::*;
#(
  parameter int DATA_BITS = proj_pkg::KMER_BUFFER_BITS,
  parameter int KMER_LEN  = proj_pkg::KMER_BUFFER_LEN,
  parameter int WORD_NUCS = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [WORD_NUCS*DATA_BITS-1:0] in_word,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           in_last,
  input  logic [$clog2(WORD_NUCS):0]     in_count,
  output logic [DATA_BITS-1:0]           out_data,
  output logic                           out_valid,
  output logic                           out_start_over,
  output logic                           out_kmer_valid,
  output logic                           out_seq_done
);

  localparam int CW = $clog2(WORD_NUCS) + 1;
  localparam int KW = $clog2(KMER_LEN + 1);
  localparam int WW = WORD_NUCS * DATA_BITS;

  typedef enum logic [1:0] {
    IDLE, CLEAR, STREAM, WAIT
  } state_t;

  state_t              state_q;
  logic [CW-1:0]       idx_q;
  logic [CW-1:0]       lim_q;
  logic                last_q;
  logic [WW-1:0]       word_q;
  logic [KW-1:0]       cnt_q;
  logic                rdy_q;
  logic                valid_q;
  logic [DATA_BITS-1:0] data_q;
  logic                so_q;
  logic                kv_q;
  logic                done_q;

  logic                xfer;
  logic [CW-1:0]       lim_in;
  logic [KW-1:0]       cnt_inc;
  logic                fin;
  logic [CW-1:0]       idx_nx;

  function automatic logic [DATA_BITS-1:0] nuc(
    input logic [WW-1:0] w,
    input logic [CW-1:0] i
  );
    logic [WW-1:0] s;
    s = w >> (32'(i) * DATA_BITS);
    return s[DATA_BITS-1:0];
  endfunction

  assign xfer   = in_valid && rdy_q;
  assign fin    = (idx_q + CW'(1)) == lim_q;
  assign idx_nx = idx_q + CW'(1);

  // Out-of-range counts on a last word mean a full word.
  always_comb begin
    lim_in = CW'(WORD_NUCS);
    if (in_last && in_count != '0 && in_count <= CW'(WORD_NUCS))
      lim_in = in_count;
  end

  assign cnt_inc = (cnt_q == KW'(KMER_LEN)) ? cnt_q : cnt_q + KW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      lim_q   <= '0;
      last_q  <= 1'b0;
      word_q  <= '0;
      cnt_q   <= '0;
      rdy_q   <= 1'b1;
      valid_q <= 1'b0;
      data_q  <= '0;
      so_q    <= 1'b0;
      kv_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      so_q    <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      unique case (state_q)
        IDLE: begin
          if (xfer) begin
            word_q  <= in_word;
            last_q  <= in_last;
            lim_q   <= lim_in;
            cnt_q   <= '0;
            kv_q    <= 1'b0;
            so_q    <= 1'b1;
            rdy_q   <= 1'b0;
            state_q <= CLEAR;
          end
        end
        CLEAR: begin
          state_q <= STREAM;
          idx_q   <= '0;
          valid_q <= 1'b1;
          data_q  <= nuc(word_q, '0);
          rdy_q   <= (lim_q == CW'(1)) && !last_q;
        end
        STREAM: begin
          cnt_q <= cnt_inc;
          kv_q  <= cnt_inc == KW'(KMER_LEN);
          if (!fin) begin
            idx_q   <= idx_nx;
            valid_q <= 1'b1;
            data_q  <= nuc(word_q, idx_nx);
            // Ready opens on the final index of a non-last word.
            rdy_q   <= (idx_q + CW'(2) == lim_q) && !last_q;
          end else if (last_q) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
            rdy_q   <= 1'b1;
          end else if (xfer) begin
            word_q  <= in_word;
            last_q  <= in_last;
            lim_q   <= lim_in;
            idx_q   <= '0;
            valid_q <= 1'b1;
            data_q  <= nuc(in_word, '0);
            rdy_q   <= (lim_in == CW'(1)) && !in_last;
          end else begin
            state_q <= WAIT;
            rdy_q   <= 1'b1;
          end
        end
        WAIT: begin
          if (xfer) begin
            word_q  <= in_word;
            last_q  <= in_last;
            lim_q   <= lim_in;
            idx_q   <= '0;
            valid_q <= 1'b1;
            data_q  <= nuc(in_word, '0);
            rdy_q   <= (lim_in == CW'(1)) && !in_last;
            state_q <= STREAM;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready       = rdy_q;
  assign out_valid      = valid_q;
  assign out_data       = data_q;
  assign out_start_over = so_q;
  assign out_kmer_valid = kv_q;
  assign out_seq_done   = done_q;

endmodule
